// File: rtl/display_timing_counter_if.sv
// ---------------------------------------------------------------------------
// display_timing_counter_if
//   Groups the raster counter's control inputs and timing outputs.
//   master : driver side (pixel-clock enable logic / consumer of timing)
//   slave  : the counter itself
//   Signals:
//     PixEn, Restart          - advance one pixel / synchronous clear
//     PixelOut, LineOut       - current raster position (CNT_W bits)
//     HSync, VSync            - registered syncs, level set by SYNC_POL
//     DataEnable              - registered, high inside the active area
//     LineEnd, FrameEnd       - combinational "wrap on next edge" pulses
// ---------------------------------------------------------------------------
interface display_timing_counter_if #(
    parameter int CNT_W = 10
);
    logic             PixEn;
    logic             Restart;
    logic [CNT_W-1:0] PixelOut;
    logic [CNT_W-1:0] LineOut;
    logic             HSync;
    logic             VSync;
    logic             DataEnable;
    logic             LineEnd;
    logic             FrameEnd;

    modport master (
        output PixEn, Restart,
        input  PixelOut, LineOut, HSync, VSync, DataEnable, LineEnd, FrameEnd
    );

    modport slave (
        input  PixEn, Restart,
        output PixelOut, LineOut, HSync, VSync, DataEnable, LineEnd, FrameEnd
    );
endinterface

// File: rtl/display_timing_counter.sv
// ---------------------------------------------------------------------------
// display_timing_counter
//   Pixel/line raster counter with registered HSync, VSync and DataEnable.
//   Porch/sync widths and sync polarity are per-instance parameters.
//   Ports:
//     clk   - system clock, all state changes on posedge
//     Reset - asynchronous, active-high; forces position (0,0), syncs
//             deasserted, DataEnable high
//     bus   - slave modport: PixEn/Restart in, position and timing out
// ---------------------------------------------------------------------------
module display_timing_counter #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CNT_W    = 10,
    parameter int SYNC_POL = 0
) (
    input logic                     clk,
    input logic                     Reset,
    display_timing_counter_if.slave bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if ((longint'(H_TOTAL) - 1) >= (longint'(1) << CNT_W) ||
        (longint'(V_TOTAL) - 1) >= (longint'(1) << CNT_W)) begin : g_width_chk
        $fatal(1, "display_timing_counter: H_TOTAL-1 or V_TOTAL-1 does not fit in CNT_W bits");
    end

    // Decode bounds are one bit wider than the counters: a sync window that
    // ends exactly at the total (zero back porch) must still be representable.
    localparam int EW = CNT_W + 1;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [EW-1:0]    ext_t;

    localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
    localparam ext_t H_ACT   = ext_t'(H_ACTIVE);
    localparam ext_t V_ACT   = ext_t'(V_ACTIVE);
    localparam ext_t HS_BEG  = ext_t'(H_ACTIVE + H_FP);
    localparam ext_t HS_END  = ext_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam ext_t VS_BEG  = ext_t'(V_ACTIVE + V_FP);
    localparam ext_t VS_END  = ext_t'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic SYNC_ON = (SYNC_POL != 0);

    cnt_t pix_q, line_q;
    cnt_t pix_d, line_d;
    logic hs_q, vs_q, de_q;
    logic hs_d, vs_d, de_d;
    logic h_last, v_last;

    assign h_last = (pix_q == H_LAST);
    assign v_last = (line_q == V_LAST);

    // Next position; Restart beats PixEn.
    always_comb begin
        pix_d  = pix_q;
        line_d = line_q;
        if (bus.Restart) begin
            pix_d  = '0;
            line_d = '0;
        end else if (bus.PixEn) begin
            if (h_last) begin
                pix_d  = '0;
                line_d = v_last ? cnt_t'(0) : line_q + cnt_t'(1);
            end else begin
                pix_d  = pix_q + cnt_t'(1);
            end
        end
    end

    // Timing outputs are decoded from the next position so they land on the
    // same edge as the counters. When nothing advances, next == current and
    // the registers simply reload their own values.
    always_comb begin
        hs_d = (({1'b0, pix_d}  >= HS_BEG) && ({1'b0, pix_d}  < HS_END)) ? SYNC_ON : ~SYNC_ON;
        vs_d = (({1'b0, line_d} >= VS_BEG) && ({1'b0, line_d} < VS_END)) ? SYNC_ON : ~SYNC_ON;
        de_d = ({1'b0, pix_d} < H_ACT) && ({1'b0, line_d} < V_ACT);
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            pix_q  <= '0;
            line_q <= '0;
            hs_q   <= ~SYNC_ON;
            vs_q   <= ~SYNC_ON;
            de_q   <= 1'b1;
        end else begin
            pix_q  <= pix_d;
            line_q <= line_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
        end
    end

    assign bus.PixelOut   = pix_q;
    assign bus.LineOut    = line_q;
    assign bus.HSync      = hs_q;
    assign bus.VSync      = vs_q;
    assign bus.DataEnable = de_q;
    // Reported even when Restart will pre-empt the wrap.
    assign bus.LineEnd    = bus.PixEn & h_last;
    assign bus.FrameEnd   = bus.PixEn & h_last & v_last;

endmodule

// File: doc/display_timing_counter.md
Name: display_timing_counter

Overview:
- Parametrised successor to the single line counter.
- Generates both pixel and line counts for one raster, plus registered HSync, VSync and DataEnable.
- Sits between the pixel-clock enable logic and the pixel fetch/output stage.
- Timing (active, front porch, sync, back porch) and sync polarity are set per instance, so one block covers several display modes.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CNT_W, 10, width of PixelOut and LineOut
- SYNC_POL, 0, sync assertion level (0 = active-low, 1 = active-high)

Ports:
- clk  input  1  system clock; all state changes on posedge clk
- Reset  input  1  asynchronous, active-high reset
- PixEn  input  1  advance one pixel this cycle
- Restart  input  1  synchronous clear of both counters to 0
- PixelOut  output  CNT_W  current horizontal position
- LineOut  output  CNT_W  current vertical position
- HSync  output  1  horizontal sync, level per SYNC_POL
- VSync  output  1  vertical sync, level per SYNC_POL
- DataEnable  output  1  high while position is inside the active area
- LineEnd  output  1  high while PixelOut == H_TOTAL-1 and PixEn == 1
- FrameEnd  output  1  high while LineEnd == 1 and LineOut == V_TOTAL-1

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Elaboration check: H_TOTAL-1 and V_TOTAL-1 must fit in CNT_W bits; otherwise stop with an error.
- Reset asserted (asynchronous, overrides everything):
  - PixelOut = 0, LineOut = 0
  - HSync = VSync = ~SYNC_POL (deasserted)
  - DataEnable = 1 (position 0,0 is active)
- Priority per clock edge: Reset > Restart > PixEn.
- Restart = 1: next state is PixelOut = 0, LineOut = 0, outputs re-decoded for position 0,0. PixEn is ignored that cycle.
- PixEn = 1 and Restart = 0:
  - PixelOut increments.
  - At PixelOut == H_TOTAL-1, PixelOut wraps to 0 and LineOut increments.
  - At LineOut == V_TOTAL-1, LineOut also wraps to 0.
- PixEn = 0: all registered outputs hold.
- HSync, VSync and DataEnable are registered. They are decoded from the next-state counters, so they change on the same edge as the counters. No skew, no extra latency.
- HSync asserted (= SYNC_POL) when H_ACTIVE+H_FP <= PixelOut < H_ACTIVE+H_FP+H_SYNC.
- VSync asserted when V_ACTIVE+V_FP <= LineOut < V_ACTIVE+V_FP+V_SYNC. It holds for whole lines regardless of PixelOut.
- DataEnable = (PixelOut < H_ACTIVE) && (LineOut < V_ACTIVE).
- LineEnd and FrameEnd are combinational from registered state and PixEn. Each pulse means "wrap on the next edge".
- Restart in the same cycle as a wrap: Restart wins. LineEnd/FrameEnd still reflect the current inputs.
- Reset mid-frame: counters return to 0 immediately and sync outputs deassert without waiting for a clock edge.
- Arithmetic is unsigned. Comparisons use CNT_W-bit counters against constants computed at elaboration.

Test Plan:
- Small config (H 4/1/2/1, total 8; V 3/1/1/1, total 6; SYNC_POL = 0), Reset pulse, then PixEn held high for 8 cycles -> PixelOut runs 0..7 then 0; LineOut goes 0->1 on the wrap edge; HSync = 0 exactly at PixelOut 5,6; DataEnable = 1 at PixelOut 0..3; LineEnd high only at PixelOut = 7.
- Same config, PixEn high for 48 cycles -> LineOut runs 0..5 then 0; VSync = 0 for all of line 4; FrameEnd high exactly once, at (7,5); state returns to (0,0).
- PixEn toggled 1,0,0,1 -> counters advance only on the PixEn = 1 edges; HSync, VSync and DataEnable are unchanged across the hold cycles.
- Restart asserted at (6,4) with PixEn = 1 -> next state (0,0); HSync = VSync = 1; DataEnable = 1; no extra line increment.
- Reset asserted asynchronously between edges at (5,4) -> PixelOut and LineOut become 0 and HSync = VSync = 1 before the next posedge; counting resumes after release.
- SYNC_POL = 1 with default 640x480 timing -> HSync = 1 for PixelOut 656..751; VSync = 1 for LineOut 490..491; wrap occurs at PixelOut 799 and LineOut 524.
